// File: rtl/ro_measure_ctrl.sv
// rtl/ro_measure_ctrl.sv - ring oscillator settle/gate/count sequencer; optional two-ring compare via RO_COMPARE_EN
module ro_measure_ctrl #(
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              sel,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              ro3_in,
    input  logic              ro5_in,
    output logic              en3,
    output logic              en5,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
`ifdef RO_COMPARE_EN
    ,
    input  logic              cmp_req,
    output logic              cmp_gt,
    output logic [CNT_W-1:0]  count_a
`endif
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               sel_q, sel_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    // [0] first sync stage, [1] second sync stage, [2] edge-detect history
    logic [2:0]         sync3_q, sync3_d;
    logic [2:0]         sync5_q, sync5_d;

`ifdef RO_COMPARE_EN
    logic               cmp_q, cmp_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
    logic               sat_a_q, sat_a_d;
    logic [CNT_W-1:0]   count_a_q, count_a_d;
    logic               cmp_gt_q, cmp_gt_d;
`endif

    logic               ring_sel;
    logic               ring_active;
    logic               ring_edge;
    logic               win_end;

    // In compare mode the ring follows the phase (ring3 first, then ring5);
    // otherwise it follows the sel captured at start.
`ifdef RO_COMPARE_EN
    assign ring_sel = cmp_q ? phase_q : sel_q;
`else
    assign ring_sel = sel_q;
`endif

    assign ring_active = (state_q == S_SETTLE) || (state_q == S_MEASURE);
    assign en3         = ring_active & ~ring_sel;
    assign en5         = ring_active &  ring_sel;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign count       = count_q;
    assign ovf         = ovf_q;
`ifdef RO_COMPARE_EN
    assign cmp_gt      = cmp_gt_q;
    assign count_a     = count_a_q;
`endif

    // Rising edge of the selected ring after the two-stage synchronizer.
    assign ring_edge = ring_sel ? (sync5_q[1] & ~sync5_q[2])
                                : (sync3_q[1] & ~sync3_q[2]);

    // Next-state, window timing, saturating edge counter and result capture.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        gate_d    = gate_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        sync3_d   = {sync3_q[1:0], ro3_in};
        sync5_d   = {sync5_q[1:0], ro5_in};
        win_end   = 1'b0;
`ifdef RO_COMPARE_EN
        cmp_d     = cmp_q;
        phase_d   = phase_q;
        cnt_a_d   = cnt_a_q;
        sat_a_d   = sat_a_q;
        count_a_d = count_a_q;
        cmp_gt_d  = cmp_gt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_SETTLE;
                    sel_d   = sel;
                    gate_d  = gate_len;
                    timer_d = TMR_W'(SETTLE_CYCLES - 1);
                    cnt_d   = '0;
                    sat_d   = 1'b0;
`ifdef RO_COMPARE_EN
                    cmp_d   = cmp_req;
                    phase_d = 1'b0;
                    cnt_a_d = '0;
                    sat_a_d = 1'b0;
`endif
                end
            end
            S_SETTLE: begin
                if (timer_q == '0) begin
                    if (gate_q == '0) begin
                        win_end = 1'b1;
                    end else begin
                        state_d = S_MEASURE;
                        timer_d = TMR_W'(gate_q) - TMR_W'(1);
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_MEASURE: begin
                if (ring_edge) begin
                    if (&cnt_q) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (timer_q == '0) begin
                    win_end = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // End of a measurement window: either start the ring5 half of a
        // compare run, or publish the result in DONE. cnt_d already holds
        // the final cycle's edge.
        if (win_end) begin
`ifdef RO_COMPARE_EN
            if (cmp_q && !phase_q) begin
                phase_d = 1'b1;
                cnt_a_d = cnt_d;
                sat_a_d = sat_d;
                cnt_d   = '0;
                sat_d   = 1'b0;
                state_d = S_SETTLE;
                timer_d = TMR_W'(SETTLE_CYCLES - 1);
            end else begin
                state_d = S_DONE;
                count_d = cnt_d;
                ovf_d   = sat_d | sat_a_q;
                if (cmp_q) begin
                    count_a_d = cnt_a_q;
                    cmp_gt_d  = (cnt_a_q > cnt_d);
                end
            end
`else
            state_d = S_DONE;
            count_d = cnt_d;
            ovf_d   = sat_d;
`endif
        end

        // Abort overrides everything: back to IDLE, published results untouched.
        if (abort) begin
            state_d   = S_IDLE;
            count_d   = count_q;
            ovf_d     = ovf_q;
`ifdef RO_COMPARE_EN
            count_a_d = count_a_q;
            cmp_gt_d  = cmp_gt_q;
`endif
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            gate_q    <= '0;
            timer_q   <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            sync3_q   <= '0;
            sync5_q   <= '0;
`ifdef RO_COMPARE_EN
            cmp_q     <= 1'b0;
            phase_q   <= 1'b0;
            cnt_a_q   <= '0;
            sat_a_q   <= 1'b0;
            count_a_q <= '0;
            cmp_gt_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            gate_q    <= gate_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            sync3_q   <= sync3_d;
            sync5_q   <= sync5_d;
`ifdef RO_COMPARE_EN
            cmp_q     <= cmp_d;
            phase_q   <= phase_d;
            cnt_a_q   <= cnt_a_d;
            sat_a_q   <= sat_a_d;
            count_a_q <= count_a_d;
            cmp_gt_q  <= cmp_gt_d;
`endif
        end
    end

endmodule
